// File: rtl/forwarding_scoreboard_pkg.sv
// Shared pipeline types for operand forwarding: register ids, forwarding sources, history entries.
// Struct value fields are DATA_W wide; the forwarding block's XLEN follows this width.
package pipeline_signals;

  typedef logic [4:0] RegisterID_t;

  localparam RegisterID_t REG_ZERO = 5'd0;
  localparam int unsigned DATA_W   = 32;

  typedef struct packed {
    logic              reg_write;
    RegisterID_t       rd;
    logic [DATA_W-1:0] value;
    logic              value_valid;
  } FwdSource_t;

  typedef struct packed {
    logic              valid;
    RegisterID_t       rd;
    logic [DATA_W-1:0] value;
  } HistEntry_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/forwarding_scoreboard_port_mux.sv
// Priority search for one read port: in-flight stages (youngest first), then committed history.
// A matching stage without a ready value requests a stall and hides every older source.
module forward_port_mux
  import pipeline_signals::*;
#(
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned HIST_DEPTH     = 1,
  parameter int unsigned XLEN           = DATA_W
) (
  input  RegisterID_t                     rs_i,
  input  logic                            rs_used_i,
  input  FwdSource_t [NUM_FWD_STAGES-1:0] fwd_src_i,
  input  HistEntry_t [HIST_DEPTH-1:0]     hist_i,
  output logic                            forward_o,
  output logic [XLEN-1:0]                 value_o,
  output logic                            stall_o
);

  logic hit;

  always_comb begin
    forward_o = 1'b0;
    value_o   = '0;
    stall_o   = 1'b0;
    hit       = 1'b0;
    if (rs_used_i && (rs_i != REG_ZERO)) begin
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
        if (!hit && fwd_src_i[k].reg_write && (fwd_src_i[k].rd == rs_i)) begin
          hit = 1'b1;
          if (fwd_src_i[k].value_valid) begin
            forward_o = 1'b1;
            value_o   = fwd_src_i[k].value;
          end else begin
            stall_o = 1'b1;
          end
        end
      end
      // Entry 0 is the most recent commit.
      for (int h = 0; h < HIST_DEPTH; h++) begin
        if (!hit && hist_i[h].valid && (hist_i[h].rd == rs_i)) begin
          hit       = 1'b1;
          forward_o = 1'b1;
          value_o   = hist_i[h].value;
        end
      end
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Operand forwarding and hazard detection at decode/execute: per-port muxes, long-latency scoreboard,
// committed-writeback history. Forward/stall outputs are combinational; pending count and error are registered.
module forwarding_scoreboard
  import pipeline_signals::*;
#(
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned HIST_DEPTH     = 1,
  parameter int unsigned XLEN           = DATA_W
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  RegisterID_t [NUM_READ_PORTS-1:0]      i_rs,
  input  logic        [NUM_READ_PORTS-1:0]      i_rs_used,
  input  FwdSource_t  [NUM_FWD_STAGES-1:0]      i_fwd_src,
  input  logic                                  i_wb_valid,
  input  RegisterID_t                           i_wb_rd,
  input  logic        [XLEN-1:0]                i_wb_value,
  input  logic                                  i_issue_valid,
  input  RegisterID_t                           i_issue_rd,
  input  logic                                  i_complete_valid,
  input  RegisterID_t                           i_complete_rd,
  input  logic                                  i_flush,
  output logic        [NUM_READ_PORTS-1:0]      o_forward,
  output logic        [NUM_READ_PORTS-1:0][XLEN-1:0] o_forward_value,
  output logic                                  o_stall,
  output logic        [5:0]                     o_pending_count,
  output logic                                  o_sb_error
);

  logic [31:0]                 sb_q, sb_d;
  logic [31:0]                 pend_eff;
  HistEntry_t [HIST_DEPTH-1:0] hist_q, hist_d;
  logic [5:0]                  count_q;
  logic                        err_q, err_d;
  logic [NUM_READ_PORTS-1:0]   port_stall;
  logic                        sb_stall;
  logic                        waw_stall;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    forward_port_mux #(
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .HIST_DEPTH     (HIST_DEPTH),
      .XLEN           (XLEN)
    ) u_mux (
      .rs_i      (i_rs[p]),
      .rs_used_i (i_rs_used[p]),
      .fwd_src_i (i_fwd_src),
      .hist_i    (hist_q),
      .forward_o (o_forward[p]),
      .value_o   (o_forward_value[p]),
      .stall_o   (port_stall[p])
    );
  end

  always_comb begin
    // A completing op's result already sits on a forwarding stage, so its bit counts as clear now.
    pend_eff = sb_q;
    if (i_complete_valid) begin
      pend_eff[i_complete_rd] = 1'b0;
    end

    sb_stall = 1'b0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if (i_rs_used[p] && pend_eff[i_rs[p]]) begin
        sb_stall = 1'b1;
      end
    end

    waw_stall = i_issue_valid && (i_issue_rd != REG_ZERO) && pend_eff[i_issue_rd];

    err_d = err_q | (i_complete_valid && !sb_q[i_complete_rd]);

    sb_d = pend_eff;
    if (i_issue_valid && (i_issue_rd != REG_ZERO) && !waw_stall) begin
      sb_d[i_issue_rd] = 1'b1;
    end
    if (i_flush) begin
      sb_d = '0;
    end
    sb_d[0] = 1'b0;
  end

  // History keeps committed writes regardless of stall or flush.
  always_comb begin
    hist_d[0].valid = i_wb_valid && (i_wb_rd != REG_ZERO);
    hist_d[0].rd    = i_wb_rd;
    hist_d[0].value = i_wb_value;
    for (int h = 1; h < HIST_DEPTH; h++) begin
      hist_d[h] = hist_q[h-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sb_q    <= '0;
      hist_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sb_q    <= sb_d;
      hist_q  <= hist_d;
      count_q <= popcount32(sb_d);
      err_q   <= err_d;
    end
  end

  assign o_stall         = (|port_stall) | sb_stall | waw_stall;
  assign o_pending_count = count_q;
  assign o_sb_error      = err_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: expectations queued at drive time, drained at sample time.
module tb_forwarding_scoreboard;
  import pipeline_signals::*;

  localparam int unsigned NRP = 2;
  localparam int unsigned NFS = 2;
  localparam int unsigned HD  = 1;
  localparam int unsigned XW  = 32;

  logic                        clk = 1'b0;
  logic                        reset_n;
  RegisterID_t [NRP-1:0]       rs;
  logic        [NRP-1:0]       rs_used;
  FwdSource_t  [NFS-1:0]       fwd;
  logic                        wb_valid;
  RegisterID_t                 wb_rd;
  logic        [XW-1:0]        wb_value;
  logic                        issue_valid;
  RegisterID_t                 issue_rd;
  logic                        complete_valid;
  RegisterID_t                 complete_rd;
  logic                        flush;
  logic        [NRP-1:0]       o_forward;
  logic        [NRP-1:0][XW-1:0] o_forward_value;
  logic                        o_stall;
  logic        [5:0]           o_pending_count;
  logic                        o_sb_error;

  always #5 clk = ~clk;

  forwarding_scoreboard #(
    .NUM_READ_PORTS (NRP),
    .NUM_FWD_STAGES (NFS),
    .HIST_DEPTH     (HD),
    .XLEN           (XW)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_rs             (rs),
    .i_rs_used        (rs_used),
    .i_fwd_src        (fwd),
    .i_wb_valid       (wb_valid),
    .i_wb_rd          (wb_rd),
    .i_wb_value       (wb_value),
    .i_issue_valid    (issue_valid),
    .i_issue_rd       (issue_rd),
    .i_complete_valid (complete_valid),
    .i_complete_rd    (complete_rd),
    .i_flush          (flush),
    .o_forward        (o_forward),
    .o_forward_value  (o_forward_value),
    .o_stall          (o_stall),
    .o_pending_count  (o_pending_count),
    .o_sb_error       (o_sb_error)
  );

  typedef enum int {S_FWD, S_VAL, S_STALL, S_CNT, S_ERR} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic FwdSource_t mk_src(input logic rw, input RegisterID_t rd,
                                       input logic [31:0] v, input logic vv);
    FwdSource_t s;
    s.reg_write   = rw;
    s.rd          = rd;
    s.value       = v;
    s.value_valid = vv;
    return s;
  endfunction

  task automatic expect_val(input string tag, input sig_e sig, input int port, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.sig  = sig;
    e.port = port;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sig_e sig, input int port);
    case (sig)
      S_FWD:   return {31'd0, o_forward[port]};
      S_VAL:   return o_forward_value[port];
      S_STALL: return {31'd0, o_stall};
      S_CNT:   return {26'd0, o_pending_count};
      default: return {31'd0, o_sb_error};
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.sig, e.port);
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    rs             = '0;
    rs_used        = '0;
    fwd            = '0;
    wb_valid       = 1'b0;
    wb_rd          = '0;
    wb_value       = '0;
    issue_valid    = 1'b0;
    issue_rd       = '0;
    complete_valid = 1'b0;
    complete_rd    = '0;
    flush          = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #4;
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    expect_val("rst_cnt",   S_CNT,   0, 32'd0);
    expect_val("rst_err",   S_ERR,   0, 32'd0);
    expect_val("rst_fwd0",  S_FWD,   0, 32'd0);
    expect_val("rst_fwd1",  S_FWD,   1, 32'd0);
    expect_val("rst_val0",  S_VAL,   0, 32'd0);
    expect_val("rst_stall", S_STALL, 0, 32'd0);
    #3;
    drain();
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Youngest stage wins over older one
    next_cycle();
    fwd[0] = mk_src(1'b1, 5'd5, 32'h11, 1'b1);
    fwd[1] = mk_src(1'b1, 5'd5, 32'h22, 1'b1);
    rs[0] = 5'd5; rs_used[0] = 1'b1;
    expect_val("young_fwd",   S_FWD,   0, 32'd1);
    expect_val("young_val",   S_VAL,   0, 32'h11);
    expect_val("young_stall", S_STALL, 0, 32'd0);
    settle();

    next_cycle();
    fwd[1] = mk_src(1'b1, 5'd5, 32'h22, 1'b1);
    rs[0] = 5'd5; rs_used[0] = 1'b1;
    expect_val("old_fwd", S_FWD, 0, 32'd1);
    expect_val("old_val", S_VAL, 0, 32'h22);
    settle();

    // Load-use: unready stage hides a ready older one
    next_cycle();
    fwd[0] = mk_src(1'b1, 5'd7, 32'h0, 1'b0);
    fwd[1] = mk_src(1'b1, 5'd7, 32'h77, 1'b1);
    rs[1] = 5'd7; rs_used[1] = 1'b1;
    expect_val("lu_stall", S_STALL, 0, 32'd1);
    expect_val("lu_fwd1",  S_FWD,   1, 32'd0);
    expect_val("lu_val1",  S_VAL,   1, 32'd0);
    settle();

    next_cycle();
    fwd[0] = mk_src(1'b1, 5'd7, 32'h0, 1'b0);
    rs[1] = 5'd7; rs_used[1] = 1'b0;
    expect_val("lu_unused_stall", S_STALL, 0, 32'd0);
    expect_val("lu_unused_fwd1",  S_FWD,   1, 32'd0);
    settle();

    // History forwarding, depth 1
    next_cycle();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_value = 32'hDEAD;
    rs[0] = 5'd9; rs_used[0] = 1'b1;
    expect_val("hist_n_fwd", S_FWD, 0, 32'd0);
    settle();

    next_cycle();
    rs[0] = 5'd9; rs_used[0] = 1'b1;
    rs[1] = 5'd9; rs_used[1] = 1'b1;
    expect_val("hist_n1_fwd0", S_FWD, 0, 32'd1);
    expect_val("hist_n1_val0", S_VAL, 0, 32'hDEAD);
    expect_val("hist_n1_fwd1", S_FWD, 1, 32'd1);
    expect_val("hist_n1_val1", S_VAL, 1, 32'hDEAD);
    settle();

    next_cycle();
    rs[0] = 5'd9; rs_used[0] = 1'b1;
    expect_val("hist_n2_fwd", S_FWD, 0, 32'd0);
    expect_val("hist_n2_val", S_VAL, 0, 32'd0);
    settle();

    // Scoreboard: issue, RAW stall, WAW stall, completion
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    expect_val("iss_stall", S_STALL, 0, 32'd0);
    settle();

    next_cycle();
    rs[0] = 5'd3; rs_used[0] = 1'b1;
    expect_val("iss_cnt",       S_CNT,   0, 32'd1);
    expect_val("raw_stall",     S_STALL, 0, 32'd1);
    settle();

    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    expect_val("waw_stall", S_STALL, 0, 32'd1);
    settle();

    next_cycle();
    complete_valid = 1'b1; complete_rd = 5'd3;
    rs[0] = 5'd3; rs_used[0] = 1'b1;
    expect_val("waw_cnt",    S_CNT,   0, 32'd1);
    expect_val("cmpl_stall", S_STALL, 0, 32'd0);
    settle();

    next_cycle();
    rs[0] = 5'd3; rs_used[0] = 1'b1;
    expect_val("cmpl_cnt",   S_CNT,   0, 32'd0);
    expect_val("cmpl_err",   S_ERR,   0, 32'd0);
    expect_val("post_stall", S_STALL, 0, 32'd0);
    settle();

    // Completion to a never-issued register
    next_cycle();
    complete_valid = 1'b1; complete_rd = 5'd4;
    expect_val("err_same_cycle", S_ERR, 0, 32'd0);
    settle();

    next_cycle();
    expect_val("err_set", S_ERR, 0, 32'd1);
    settle();

    // Flush overrides same-cycle issue
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd10;
    settle();
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd11;
    expect_val("fl_cnt1", S_CNT, 0, 32'd1);
    settle();
    next_cycle();
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd12;
    expect_val("fl_cnt2", S_CNT, 0, 32'd2);
    settle();
    next_cycle();
    rs[0] = 5'd12; rs_used[0] = 1'b1;
    rs[1] = 5'd10; rs_used[1] = 1'b1;
    expect_val("fl_cnt0",   S_CNT,   0, 32'd0);
    expect_val("fl_stall",  S_STALL, 0, 32'd0);
    expect_val("err_hold",  S_ERR,   0, 32'd1);
    settle();

    // x0 never forwards
    next_cycle();
    fwd[0] = mk_src(1'b1, 5'd0, 32'h55, 1'b1);
    fwd[1] = mk_src(1'b1, 5'd0, 32'h66, 1'b0);
    rs_used = 2'b11;
    expect_val("x0_fwd0",  S_FWD,   0, 32'd0);
    expect_val("x0_fwd1",  S_FWD,   1, 32'd0);
    expect_val("x0_val0",  S_VAL,   0, 32'd0);
    expect_val("x0_stall", S_STALL, 0, 32'd0);
    settle();

    // Same-cycle complete and reissue: set wins, no WAW stall
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd21;
    settle();
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd21;
    complete_valid = 1'b1; complete_rd = 5'd21;
    expect_val("sw_stall", S_STALL, 0, 32'd0);
    settle();
    next_cycle();
    expect_val("sw_cnt1", S_CNT, 0, 32'd1);
    settle();
    next_cycle();
    complete_valid = 1'b1; complete_rd = 5'd21;
    settle();
    next_cycle();
    expect_val("sw_cnt0", S_CNT, 0, 32'd0);
    settle();

    // Asynchronous reset mid-operation clears pending bits and the error
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd5;
    settle();
    next_cycle();
    expect_val("pre_rst_cnt", S_CNT, 0, 32'd1);
    settle();
    reset_n = 1'b0;
    #1;
    expect_val("arst_cnt", S_CNT, 0, 32'd0);
    expect_val("arst_err", S_ERR, 0, 32'd0);
    drain();
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    rs[0] = 5'd5; rs_used[0] = 1'b1;
    expect_val("post_rst_stall", S_STALL, 0, 32'd0);
    expect_val("post_rst_err",   S_ERR,   0, 32'd0);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
# forwarding_scoreboard

Parametrised operand-forwarding and hazard block for the decode/execute boundary of the RISC-V pipeline.
- Resolves each register read port against N in-flight pipeline stages and a short history buffer of committed writebacks.
- Tracks destinations of long-latency operations (mul/div/etc.) in a scoreboard.
- Raises a stall when an operand is not yet available.
- Replaces the fixed two-stage, two-port forwarding logic.

## Interface
Parameters:
- NUM_READ_PORTS, 2, number of operand read ports resolved in parallel
- NUM_FWD_STAGES, 2, in-flight forwarding sources; index 0 is youngest
- HIST_DEPTH, 1, committed-writeback history entries (1..4)
- XLEN, 32, datapath width

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_rs  in  NUM_READ_PORTS x RegisterID_t  source register per port
- i_rs_used  in  NUM_READ_PORTS  port actually reads its register
- i_fwd_src  in  NUM_FWD_STAGES x FwdSource_t  {reg_write, rd, value, value_valid} per stage
- i_wb_valid, i_wb_rd, i_wb_value  in  1 / 5 / XLEN  register-file commit this cycle
- i_issue_valid, i_issue_rd  in  1 / 5  long-latency op issued with destination rd
- i_complete_valid, i_complete_rd  in  1 / 5  long-latency op finished
- i_flush  in  1  pipeline flush; in-flight long-latency ops are aborted
- o_forward  out  NUM_READ_PORTS  use forwarded value
- o_forward_value  out  NUM_READ_PORTS x XLEN  forwarded value; 0 when o_forward=0
- o_stall  out  1  decode must hold
- o_pending_count  out  6  scoreboard bits set
- o_sb_error  out  1  sticky protocol error

## Operation

Per-port resolution applies only when i_rs_used[p] is set and i_rs[p]!=0. Highest priority wins:
1. Stage k, ascending from 0, with reg_write && rd==i_rs[p] && rd!=0.
   - If value_valid, forward value.
   - Otherwise, assert o_stall for the load-use case. The search stops and older sources are not consulted.
2. Valid history entry with rd==i_rs[p], newest first: forward its value.
3. No match: o_forward[p]=0 and the register file supplies the value.

Scoreboard (32 bits, x0 hard-wired clear):
- Set on i_issue_valid && i_issue_rd!=0.
- Cleared on i_complete_valid.
- Complete in the same cycle as issue to the same rd leaves the bit set; set wins.
- A pending bit matching any used i_rs[p] asserts o_stall.
- The bit is treated as clear in its completion cycle; the result is then present on a forwarding stage.
- WAW: i_issue_valid to an already-pending rd asserts o_stall. No set occurs that cycle.
- i_flush clears all bits at the next edge and overrides a same-cycle issue.
- Complete to a non-pending rd is ignored and sets o_sb_error.

History buffer:
- Shift register of {valid, rd, value}.
- Each edge shifts in {i_wb_valid && i_wb_rd!=0, i_wb_rd, i_wb_value}; the oldest entry is dropped.
- It covers register files without write-through.
- It is unaffected by i_flush because committed writes remain architecturally valid.
- It shifts every cycle, independent of o_stall.

## Timing
- o_forward, o_forward_value and o_stall are combinational from inputs and current state, with zero latency.
- Scoreboard, history and o_sb_error update on the rising edge of i_clk.
- o_pending_count is registered and reflects state after the last edge.
- Reset, asynchronous on i_reset_n low:
  - Scoreboard clear, all history entries invalid.
  - o_pending_count=0, o_sb_error=0.
  - o_forward=0, o_forward_value=0, o_stall=0 while inputs are idle.
- Reset mid-operation discards pending bits. The execution units are reset by the same signal.
- o_sb_error clears only on reset.

## Structure
- pipeline_signals package gains:
  - FwdSource_t
  - HistEntry_t
  - constant REG_ZERO
- RegisterID_t is reused.
- Sub-module forward_port_mux is instantiated NUM_READ_PORTS times. It performs the priority search for one port and returns {forward, value, stall}.
- The top level holds the scoreboard, history buffer, OR of per-port stalls, and the popcount.

## Test plan
- Stage0 {1,x5,0x11,1} and stage1 {1,x5,0x22,1}, rs1=x5 -> o_forward[0]=1, value 0x11 (youngest wins).
- Stage0 {1,x7,–,value_valid=0}, rs2=x7 used -> o_stall=1, o_forward[1]=0. Same with i_rs_used[1]=0 -> o_stall=0.
- Writeback x9=0xDEAD at cycle n; next cycle rs1=x9 with no stage match -> forward 0xDEAD. With HIST_DEPTH=1, cycle n+2 -> o_forward=0.
- Issue x3:
  - o_pending_count=1.
  - rs1=x3 -> stall.
  - Issue x3 again -> stall, count stays 1.
  - Complete x3 -> stall drops in the completion cycle, count=0 next cycle.
- Complete x4 never issued -> o_sb_error=1, persists until i_reset_n pulse.
- Issue x10 and x11, then i_flush together with issue x12 -> count=0 after edge. rs=x0 from any stage with rd=x0 -> never forwards.
